// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers decoded ALU instructions in a FIFO and issues them
// to the ALU as single-cycle ACT pulses while the ALU is ready. The number of
// instructions in flight (issued, result not yet returned) is capped.
module alu_issue_queue #(
    parameter int pDataWidth      = 8,
    parameter int pFifoDepth      = 8,
    parameter int pMaxOutstanding = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          IN_VLD,
    output logic                          IN_RDY,
    input  logic [3:0]                    IN_OP,
    input  logic [1:0]                    IN_MOVI,
    input  logic [pDataWidth-1:0]         IN_REG_A,
    input  logic [pDataWidth-1:0]         IN_REG_B,
    input  logic [pDataWidth-1:0]         IN_IMM,
    input  logic [pDataWidth-1:0]         IN_MEM,
    output logic                          ACT,
    input  logic                          ALU_RDY,
    output logic [3:0]                    OP,
    output logic [1:0]                    MOVI,
    output logic [pDataWidth-1:0]         REG_A,
    output logic [pDataWidth-1:0]         REG_B,
    output logic [pDataWidth-1:0]         IMM,
    output logic [pDataWidth-1:0]         MEM,
    input  logic                          EX_ALU_VLD,
    output logic [$clog2(pFifoDepth):0]   FIFO_CNT,
    output logic [3:0]                    OUTSTANDING,
    output logic                          ERR
);

    localparam int PW = $clog2(pFifoDepth);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]            op;
        logic [1:0]            movi;
        logic [pDataWidth-1:0] regA;
        logic [pDataWidth-1:0] regB;
        logic [pDataWidth-1:0] imm;
        logic [pDataWidth-1:0] mem;
    } entry_t;

    entry_t          fifo_q [pFifoDepth];
    entry_t          issued_q;
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      outst_q, outst_d;
    logic            err_q, err_d;
    logic            act_q;
    logic            push, issue;
    entry_t          inEntry;

    assign inEntry = '{op: IN_OP, movi: IN_MOVI, regA: IN_REG_A,
                       regB: IN_REG_B, imm: IN_IMM, mem: IN_MEM};

    // Ready comes from the registered count, forced low while reset is held.
    assign IN_RDY = !RESET && (cnt_q < CW'(pFifoDepth));
    assign push   = IN_VLD && IN_RDY;
    assign issue  = (cnt_q != '0) && ALU_RDY && (outst_q < 4'(pMaxOutstanding));

    // Next-state for occupancy, in-flight count and the sticky error flag.
    always_comb begin
        cnt_d   = cnt_q;
        outst_d = outst_q;
        err_d   = err_q;
        if (push && !issue) begin
            cnt_d = cnt_q + CW'(1);
        end else if (issue && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (issue && !EX_ALU_VLD) begin
            outst_d = outst_q + 4'd1;
        end else if (EX_ALU_VLD && !issue) begin
            if (outst_q != 4'd0) begin
                outst_d = outst_q - 4'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // FIFO storage; no reset needed since pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wrPtr_q] <= inEntry;
        end
    end

    // Pointers, counters, and the issue register that drives the ALU.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            cnt_q    <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            act_q    <= 1'b0;
            issued_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            act_q   <= issue;
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (issue) begin
                rdPtr_q  <= rdPtr_q + PW'(1);
                issued_q <= fifo_q[rdPtr_q];
            end
        end
    end

    assign ACT         = act_q;
    assign OP          = issued_q.op;
    assign MOVI        = issued_q.movi;
    assign REG_A       = issued_q.regA;
    assign REG_B       = issued_q.regB;
    assign IMM         = issued_q.imm;
    assign MEM         = issued_q.mem;
    assign FIFO_CNT    = cnt_q;
    assign OUTSTANDING = outst_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_alu_issue_queue;

    logic       CLK = 1'b0;
    logic       RESET, IN_VLD, IN_RDY, ACT, ALU_RDY, EX_ALU_VLD, ERR;
    logic [3:0] IN_OP, OP, OUTSTANDING;
    logic [1:0] IN_MOVI, MOVI;
    logic [7:0] IN_REG_A, IN_REG_B, IN_IMM, IN_MEM;
    logic [7:0] REG_A, REG_B, IMM, MEM;
    logic [3:0] FIFO_CNT;

    int checks = 0;
    int errors = 0;

    alu_issue_queue #(.pDataWidth(8), .pFifoDepth(8), .pMaxOutstanding(4)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
        .IN_OP(IN_OP), .IN_MOVI(IN_MOVI), .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B),
        .IN_IMM(IN_IMM), .IN_MEM(IN_MEM), .ACT(ACT), .ALU_RDY(ALU_RDY),
        .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B), .IMM(IMM), .MEM(MEM),
        .EX_ALU_VLD(EX_ALU_VLD), .FIFO_CNT(FIFO_CNT), .OUTSTANDING(OUTSTANDING),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, vld;
        logic [3:0] op;
        logic [1:0] movi;
        logic [7:0] a, b, imm, mem;
        logic       aluRdy, exVld;
        logic       eAct;
        logic [3:0] eOp;
        logic [1:0] eMovi;
        logic [7:0] eA, eB, eImm, eMem;
        logic [3:0] eCnt, eOut;
        logic       eRdy, eErr;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mkVec(
        input logic rst, input logic vld, input logic [3:0] op, input logic [1:0] movi,
        input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm, input logic [7:0] mem,
        input logic aluRdy, input logic exVld,
        input logic eAct, input logic [3:0] eOp, input logic [1:0] eMovi,
        input logic [7:0] eA, input logic [7:0] eB, input logic [7:0] eImm, input logic [7:0] eMem,
        input logic [3:0] eCnt, input logic [3:0] eOut, input logic eRdy, input logic eErr);
        vec_t v;
        v.rst = rst; v.vld = vld; v.op = op; v.movi = movi;
        v.a = a; v.b = b; v.imm = imm; v.mem = mem;
        v.aluRdy = aluRdy; v.exVld = exVld;
        v.eAct = eAct; v.eOp = eOp; v.eMovi = eMovi;
        v.eA = eA; v.eB = eB; v.eImm = eImm; v.eMem = eMem;
        v.eCnt = eCnt; v.eOut = eOut; v.eRdy = eRdy; v.eErr = eErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [3:0] op, input logic [1:0] movi,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] imm, input logic [7:0] mem);
        IN_VLD = vld; IN_OP = op; IN_MOVI = movi;
        IN_REG_A = a; IN_REG_B = b; IN_IMM = imm; IN_MEM = mem;
    endtask

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic doReset;
        RESET = 1'b1; EX_ALU_VLD = 1'b0; ALU_RDY = 1'b0;
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        RESET = 1'b0;
    endtask

    initial begin
        int acts;

        //                rst vld op    mv  a      b      imm    mem    rdy ex   act op   mv  a      b      imm    mem    cnt  out  irdy err
        vecs[0] = mkVec(1, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,   0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0);
        vecs[1] = mkVec(0, 1, 4'h1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 1, 0,   0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd1, 4'd0, 1, 0);
        vecs[2] = mkVec(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0,   1, 4'h1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 4'd0, 4'd1, 1, 0);
        vecs[3] = mkVec(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0,   0, 4'h1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 4'd0, 4'd1, 1, 0);
        vecs[4] = mkVec(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1,   0, 4'h1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 4'd0, 4'd0, 1, 0);
        vecs[5] = mkVec(0, 1, 4'h2, 1, 8'h07, 8'h02, 8'h11, 8'h22, 1, 0,   0, 4'h1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 4'd1, 4'd0, 1, 0);
        vecs[6] = mkVec(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0,   1, 4'h2, 1, 8'h07, 8'h02, 8'h11, 8'h22, 4'd0, 4'd1, 1, 0);
        vecs[7] = mkVec(0, 1, 4'h3, 2, 8'h09, 8'h01, 8'hC4, 8'h3D, 1, 0,   0, 4'h2, 1, 8'h07, 8'h02, 8'h11, 8'h22, 4'd1, 4'd1, 1, 0);
        vecs[8] = mkVec(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1,   1, 4'h3, 2, 8'h09, 8'h01, 8'hC4, 8'h3D, 4'd0, 4'd1, 1, 0);
        vecs[9] = mkVec(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1,   0, 4'h3, 2, 8'h09, 8'h01, 8'hC4, 8'h3D, 4'd0, 4'd0, 1, 0);

        RESET = 1'b1; ALU_RDY = 1'b0; EX_ALU_VLD = 1'b0;
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Table: reset, single op, hold, return, simultaneous issue+return.
        for (int i = 0; i < 10; i++) begin
            RESET = vecs[i].rst; ALU_RDY = vecs[i].aluRdy; EX_ALU_VLD = vecs[i].exVld;
            applyStimulus(vecs[i].vld, vecs[i].op, vecs[i].movi, vecs[i].a, vecs[i].b,
                          vecs[i].imm, vecs[i].mem);
            step();
            checkOutput($sformatf("vec%0d.ACT", i), ACT, vecs[i].eAct);
            checkOutput($sformatf("vec%0d.OP", i), OP, vecs[i].eOp);
            checkOutput($sformatf("vec%0d.MOVI", i), MOVI, vecs[i].eMovi);
            checkOutput($sformatf("vec%0d.REG_A", i), REG_A, vecs[i].eA);
            checkOutput($sformatf("vec%0d.REG_B", i), REG_B, vecs[i].eB);
            checkOutput($sformatf("vec%0d.IMM", i), IMM, vecs[i].eImm);
            checkOutput($sformatf("vec%0d.MEM", i), MEM, vecs[i].eMem);
            checkOutput($sformatf("vec%0d.FIFO_CNT", i), FIFO_CNT, vecs[i].eCnt);
            checkOutput($sformatf("vec%0d.OUTSTANDING", i), OUTSTANDING, vecs[i].eOut);
            checkOutput($sformatf("vec%0d.IN_RDY", i), IN_RDY, vecs[i].eRdy);
            checkOutput($sformatf("vec%0d.ERR", i), ERR, vecs[i].eErr);
        end

        // Fill to full with the ALU stalled, then drain in push order.
        ALU_RDY = 1'b0; EX_ALU_VLD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 2'd0, 8'h10 + 8'(i), 8'h00, 8'h00, 8'h00);
            step();
            checkOutput($sformatf("fill%0d.FIFO_CNT", i), FIFO_CNT, i + 1);
        end
        checkOutput("full.IN_RDY", IN_RDY, 0);
        applyStimulus(1'b1, 4'hF, 2'd3, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
        step();
        checkOutput("ninthIgnored.FIFO_CNT", FIFO_CNT, 8);
        checkOutput("ninthIgnored.ACT", ACT, 0);
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        ALU_RDY = 1'b1;
        for (int j = 0; j < 8; j++) begin
            EX_ALU_VLD = (j > 0);
            step();
            checkOutput($sformatf("drain%0d.ACT", j), ACT, 1);
            checkOutput($sformatf("drain%0d.REG_A", j), REG_A, 8'h10 + 8'(j));
            checkOutput($sformatf("drain%0d.OP", j), OP, j + 1);
            checkOutput($sformatf("drain%0d.OUTSTANDING", j), OUTSTANDING, 1);
            if (j == 0) begin
                checkOutput("drain0.IN_RDY", IN_RDY, 1);
                checkOutput("drain0.FIFO_CNT", FIFO_CNT, 7);
            end
        end
        EX_ALU_VLD = 1'b1;
        step();
        checkOutput("drainEnd.ACT", ACT, 0);
        checkOutput("drainEnd.OUTSTANDING", OUTSTANDING, 0);
        checkOutput("drainEnd.FIFO_CNT", FIFO_CNT, 0);

        // Outstanding throttle: six queued, only four may issue until a return.
        doReset();
        checkOutput("rst2.ERR", ERR, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'(i), 2'd0, 8'h20 + 8'(i), 8'h00, 8'h00, 8'h00);
            step();
        end
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        ALU_RDY = 1'b1;
        acts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ACT) acts++;
        end
        checkOutput("throttle.acts", acts, 4);
        checkOutput("throttle.OUTSTANDING", OUTSTANDING, 4);
        checkOutput("throttle.FIFO_CNT", FIFO_CNT, 2);
        EX_ALU_VLD = 1'b1;
        step();
        checkOutput("throttleRet.ACT", ACT, 0);
        checkOutput("throttleRet.OUTSTANDING", OUTSTANDING, 3);
        EX_ALU_VLD = 1'b0;
        acts = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ACT) acts++;
        end
        checkOutput("throttleMore.acts", acts, 1);
        checkOutput("throttleMore.OUTSTANDING", OUTSTANDING, 4);
        checkOutput("throttleMore.FIFO_CNT", FIFO_CNT, 1);
        checkOutput("throttleMore.REG_A", REG_A, 8'h24);

        // Push and pop at the same edge with three queued.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h5, 2'd0, 8'h30 + 8'(i), 8'h00, 8'h00, 8'h00);
            step();
        end
        checkOutput("pushPop.pre.FIFO_CNT", FIFO_CNT, 3);
        applyStimulus(1'b1, 4'h5, 2'd0, 8'h33, 8'h00, 8'h00, 8'h00);
        ALU_RDY = 1'b1;
        step();
        checkOutput("pushPop.FIFO_CNT", FIFO_CNT, 3);
        checkOutput("pushPop.ACT", ACT, 1);
        checkOutput("pushPop.REG_A", REG_A, 8'h30);
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        ALU_RDY = 1'b0;
        step();
        checkOutput("pushPop.post.FIFO_CNT", FIFO_CNT, 3);
        checkOutput("pushPop.post.ACT", ACT, 0);

        // Spurious result with nothing in flight sets a sticky error.
        doReset();
        EX_ALU_VLD = 1'b1;
        step();
        checkOutput("err.ERR", ERR, 1);
        checkOutput("err.OUTSTANDING", OUTSTANDING, 0);
        EX_ALU_VLD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("errSticky%0d.ERR", i), ERR, 1);
        end
        applyStimulus(1'b1, 4'h7, 2'd0, 8'h55, 8'h00, 8'h00, 8'h00);
        ALU_RDY = 1'b1;
        step();
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        checkOutput("errIssue.OUTSTANDING", OUTSTANDING, 1);
        checkOutput("errIssue.ERR", ERR, 1);
        EX_ALU_VLD = 1'b1;
        step();
        checkOutput("errRet.OUTSTANDING", OUTSTANDING, 0);
        checkOutput("errRet.ERR", ERR, 1);

        // Reset mid-stream with five queued and two in flight.
        doReset();
        checkOutput("rstClr.ERR", ERR, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 2'(i), 8'h40 + 8'(i), 8'hA0, 8'hB0, 8'hC0);
            step();
        end
        applyStimulus(1'b0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        ALU_RDY = 1'b1;
        step();
        step();
        ALU_RDY = 1'b0;
        step();
        checkOutput("mid.FIFO_CNT", FIFO_CNT, 5);
        checkOutput("mid.OUTSTANDING", OUTSTANDING, 2);
        checkOutput("mid.REG_A", REG_A, 8'h41);
        RESET = 1'b1; ALU_RDY = 1'b1;
        step();
        checkOutput("midRst.ACT", ACT, 0);
        checkOutput("midRst.FIFO_CNT", FIFO_CNT, 0);
        checkOutput("midRst.OUTSTANDING", OUTSTANDING, 0);
        checkOutput("midRst.OP", OP, 0);
        checkOutput("midRst.MOVI", MOVI, 0);
        checkOutput("midRst.REG_A", REG_A, 0);
        checkOutput("midRst.REG_B", REG_B, 0);
        checkOutput("midRst.IMM", IMM, 0);
        checkOutput("midRst.MEM", MEM, 0);
        checkOutput("midRst.IN_RDY", IN_RDY, 0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("postRst%0d.ACT", i), ACT, 0);
            checkOutput($sformatf("postRst%0d.FIFO_CNT", i), FIFO_CNT, 0);
        end
        checkOutput("postRst.IN_RDY", IN_RDY, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
